// File: rtl/sha256_sched_stream.sv
// SHA-256 message-schedule streamer.
// Accepts one 512-bit block and emits W0..W(ROUNDS-1), one word per accepted
// beat. Words W16 and up come from a 16-word sliding window and a single
// sigma0/sigma1 datapath.
// Optional build macro SHA256_SCHED_KT_EN adds o_kt, the round constant Kt for
// the current o_t, read from a 64-entry constant ROM.
module sha256_sched_stream #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic [511:0] i_blk,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  output logic [31:0]  o_w,
  output logic [5:0]   o_t,
  output logic         o_w_valid,
  input  logic         i_w_ready,
  output logic         o_last
`ifdef SHA256_SCHED_KT_EN
  ,
  output logic [31:0]  o_kt
`endif
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        load;
  logic        beat;
  logic        at_last;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign at_last = (t == T_LAST);

  // Window position 0 holds W(t), so W(t+16) needs taps 14, 9, 1 and 0.
  assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  // Next-state and handshake decode; i_clear overrides loads and beats.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    beat        = 1'b0;
    o_blk_ready = 1'b0;
    o_w_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid && !i_clear) begin
          load      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        o_w_valid = 1'b1;
        beat      = i_w_ready && !i_clear;
        if (beat && at_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (i_clear) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round counter: cleared on load, abort and the final beat so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t <= '0;
    end else if (i_clear || load || (beat && at_last)) begin
      t <= '0;
    end else if (beat) begin
      t <= t + 6'd1;
    end
  end

  // Sliding window: parallel load of the block, shift-by-one on every beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < 16; k++) begin
        win[k] <= '0;
      end
    end else if (load) begin
      for (int unsigned k = 0; k < 16; k++) begin
        win[k] <= i_blk[511 - 32 * k -: 32];
      end
    end else if (beat) begin
      for (int unsigned k = 0; k < 15; k++) begin
        win[k] <= win[k + 1];
      end
      win[15] <= w_new;
    end
  end

  assign o_w    = win[0];
  assign o_t    = t;
  assign o_last = o_w_valid && at_last;

`ifdef SHA256_SCHED_KT_EN
  function automatic logic [31:0] kt_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  // Kt follows o_t while streaming and reads zero otherwise.
  assign o_kt = o_w_valid ? kt_rom(t) : '0;
`endif

endmodule

// File: tb/tb_sha256_sched_stream.sv
// Scoreboard bench for sha256_sched_stream: the stimulus pushes the full
// schedule computed by a reference model; a negedge monitor pops and compares.
module tb_sha256_sched_stream;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [511:0] blk = '0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [31:0]  w;
  logic [5:0]   t;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic         last;
`ifdef SHA256_SCHED_KT_EN
  logic [31:0]  kt;
`endif

  sha256_sched_stream #(.ROUNDS(ROUNDS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_blk       (blk),
    .i_blk_valid (blk_valid),
    .o_blk_ready (blk_ready),
    .o_w         (w),
    .o_t         (t),
    .o_w_valid   (w_valid),
    .i_w_ready   (w_ready),
    .o_last      (last)
`ifdef SHA256_SCHED_KT_EN
    ,
    .o_kt        (kt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  t;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  logic        mon_en = 1'b0;
  logic        b2b_check = 1'b0;
  logic        armed = 1'b0;
  logic        ret_pend = 1'b0;
  int          since = 0;
  int          last_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_w = '0;
  logic [5:0]  prev_t = '0;
  logic [31:0] got [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event (time %0t)", name, $time);
  endtask

  // Reference model: plain SHA-256 schedule recurrence over a full array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] m [64];
    exp_t e;
    for (int i = 0; i < 16; i++) m[i] = b[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      m[i] = ssig1(m[i - 2]) + m[i - 7] + ssig0(m[i - 15]) + m[i - 16];
    for (int i = 0; i < ROUNDS; i++) begin
      e.w    = m[i];
      e.t    = 6'(i);
      e.last = (i == ROUNDS - 1);
      q.push_back(e);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i * 32 +: 32] = $urandom;
    return b;
  endfunction

  // Consumer ready: always high, or random stalls of 1..10 cycles.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      w_ready = 1'b1;
    end else if (stall_left > 0) begin
      w_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      stall_left = int'($urandom_range(1, 10)) - 1;
      w_ready = 1'b0;
    end else begin
      w_ready = 1'b1;
    end
  end

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ret_pend) begin
        check("ready_after_last", 32'(blk_ready), 32'd1);
        ret_pend = 1'b0;
      end
      if (armed) since++;
      if (w_valid) begin
        check("ready_vs_valid", 32'(blk_ready), 32'd0);
        if (armed && b2b_check) check("b2b_bubble", 32'(since), 32'd2);
        armed = 1'b0;
        if (prev_stall) begin
          check("stall_hold_w", w, prev_w);
          check("stall_hold_t", 32'(t), 32'(prev_t));
        end
        if (q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          e = q[0];
          check("word", w, e.w);
          check("round", 32'(t), 32'(e.t));
          check("last", 32'(last), 32'(e.last));
`ifdef SHA256_SCHED_KT_EN
          if (t == 6'd0)  check("kt_t0", kt, 32'h428a2f98);
          if (t == 6'd63) check("kt_t63", kt, 32'hc67178f2);
`endif
          if (w_ready) begin
            void'(q.pop_front());
            got[t] = w;
            if (e.last) begin
              last_cnt++;
              armed    = 1'b1;
              since    = 0;
              ret_pend = 1'b1;
            end
          end
        end
        prev_stall = !w_ready;
        prev_w     = w;
        prev_t     = t;
      end else begin
        prev_stall = 1'b0;
        check("last_idle", 32'(last), 32'd0);
`ifdef SHA256_SCHED_KT_EN
        check("kt_idle", kt, 32'd0);
`endif
      end
    end
  end

  task automatic load(input logic [511:0] b);
    int n = 0;
    @(posedge clk); #1;
    blk = b;
    blk_valid = 1'b1;
    push_block(b);
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready && n < 200);
    if (!blk_ready) fail_now("load_timeout");
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail_now("drain_timeout");
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_round(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w_valid && t == 6'(k)) && n < 500);
    if (!(w_valid && t == 6'(k))) fail_now("wait_round_timeout");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(w_valid), 32'd0);
    check({tag, "_ready"}, 32'(blk_ready), 32'd1);
    check({tag, "_w"}, w, 32'd0);
    check({tag, "_t"}, 32'(t), 32'd0);
    check({tag, "_last"}, 32'(last), 32'd0);
  endtask

  logic [511:0] abc;
  logic [511:0] blk_a;
  logic [511:0] blk_b;
  int           n;
  int           lc;

  initial begin
    abc = {32'h61626380, 448'h0, 32'h00000018};
    #3;
    check_reset_vals("reset");
    #9 rst_n = 1'b1;
    mon_en = 1'b1;

    // Scenario 1: "abc" block, consumer always ready.
    rdy_mode = 0;
    load(abc);
    wait_done();
    check("abc_w0", got[0], 32'h61626380);
    check("abc_w15", got[15], 32'h00000018);
    check("abc_w16", got[16], 32'h61626380);
    check("abc_w17", got[17], 32'h000f0000);
    check("abc_w18", got[18], 32'h7da86405);

    // Scenario 2: same block under random backpressure.
    rdy_mode = 1;
    load(abc);
    wait_done();
    check("abc_bp_w18", got[18], 32'h7da86405);

    // Scenario 3: abort at t = 20, then clear-with-valid in IDLE, then restart.
    rdy_mode = 0;
    load(rand_blk());
    wait_round(20);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    q.delete();
    @(negedge clk);
    check("clear_valid", 32'(w_valid), 32'd0);
    check("clear_ready", 32'(blk_ready), 32'd1);
    check("clear_t", 32'(t), 32'd0);
    @(posedge clk); #1;
    blk = rand_blk();
    blk_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clear_blocks_load", 32'(w_valid), 32'd0);
    load(rand_blk());
    wait_done();

    // Scenario 4: asynchronous reset mid-stream at t = 40.
    load(rand_blk());
    wait_round(40);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 1;
    load(rand_blk());
    wait_done();

    // Scenario 5: i_blk_valid held high across two blocks.
    armed = 1'b0;
    b2b_check = 1'b1;
    blk_a = rand_blk();
    blk_b = rand_blk();
    @(posedge clk); #1;
    blk = blk_a;
    blk_valid = 1'b1;
    push_block(blk_a);
    n = 0;
    do begin @(negedge clk); n++; end while (!w_valid && n < 50);
    if (!w_valid) fail_now("b2b_first_accept");
    blk = blk_b;
    push_block(blk_b);
    lc = last_cnt;
    n = 0;
    while (last_cnt == lc && n < 3000) begin @(negedge clk); n++; end
    if (last_cnt == lc) fail_now("b2b_first_done");
    n = 0;
    do begin @(negedge clk); n++; end while (!w_valid && n < 50);
    if (!w_valid) fail_now("b2b_second_accept");
    @(posedge clk); #1;
    blk_valid = 1'b0;
    wait_done();
    b2b_check = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_sched_stream.md
Name: sha256_sched_stream

Overview:
- Sequential SHA-256 message-schedule transmitter.
- Accepts one 512-bit message block through a valid/ready handshake.
- Streams W0..W(ROUNDS-1) one word per accepted beat to the compression-round engine.
- Words W16 and up are generated on the fly from a 16-word sliding window, replacing the fully unrolled W16..W63 expansion with a single sigma datapath.

Parameters:
- ROUNDS, 64: words streamed per block. Legal range 16..64; 64 for SHA-256 compliance.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous abort; returns the block to IDLE.
- i_blk  input  512  message block. W0 = [511:480], W15 = [31:0], big-endian words.
- i_blk_valid  input  1  i_blk is valid.
- o_blk_ready  output  1  block can accept a new message block.
- o_w  output  32  current schedule word Wt.
- o_t  output  6  current round index t.
- o_w_valid  output  1  o_w / o_t are valid.
- i_w_ready  input  1  consumer accepts o_w this cycle.
- o_last  output  1  high while o_t == ROUNDS-1 and o_w_valid.

Behaviour:
- Reset values (async, i_rst_n low):
  - state = IDLE, window = 0.
  - o_w = 0, o_t = 0, o_w_valid = 0, o_last = 0.
  - o_blk_ready = 1.
- States: IDLE, STREAM.
- IDLE:
  - o_blk_ready = 1, o_w_valid = 0.
  - On i_blk_valid: latch i_blk into window w[0..15] (w[0] = W0), set t = 0, go to STREAM.
  - First word is valid the cycle after acceptance (1-cycle latency).
- STREAM:
  - o_blk_ready = 0, o_w_valid = 1, o_w = w[0], o_t = t.
  - Beat = o_w_valid & i_w_ready.
  - On a beat: w[k] <= w[k+1] for k = 0..14, and w[15] <= new, where new = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0] mod 2^32. Then t <= t+1.
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - No beat: o_w, o_t and the window hold exactly stable (backpressure of any length).
- Last word:
  - A beat with t == ROUNDS-1 returns the block to IDLE.
  - o_blk_ready is high the next cycle.
  - A new block cannot be accepted in the same cycle as the last beat.
  - Back-to-back blocks therefore incur one bubble cycle.
- i_clear:
  - Wins over every other event.
  - Next state IDLE, o_w_valid = 0, t = 0; window contents are don't-care.
  - In IDLE, i_clear with i_blk_valid does not load the block.
- Async reset mid-stream: immediate return to reset values; the partial block is discarded.
- t never wraps. It counts 0..ROUNDS-1 and is cleared on load.
- i_blk_valid is ignored in STREAM. The upstream producer must hold i_blk stable until o_blk_ready is seen.

Optional Feature:
- Macro: SHA256_SCHED_KT_EN.
- Defined:
  - Adds output port o_kt [31:0], carrying round constant Kt for the current o_t, with the same valid/hold timing as o_w.
  - o_kt resets to 0 and reads 0 in IDLE.
  - Implemented as a 64-entry constant ROM indexed by t.
- Undefined: the port and ROM are absent. Behaviour is otherwise identical.

Test Plan:
1. Load the "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), i_w_ready held high, then check:
   - o_t 0..15 echo the input words.
   - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405.
   - o_last high only at t = 63.
   - o_blk_ready returns one cycle after the final beat.
2. Same block with i_w_ready toggled pseudo-randomly (stalls up to 10 cycles) -> word sequence identical to scenario 1, and o_w / o_t stable throughout every stall.
3. Assert i_clear at t = 20 -> next cycle o_w_valid = 0, o_blk_ready = 1. A fresh block is then accepted and restarts at t = 0.
4. Deassert i_rst_n asynchronously at t = 40 -> outputs return to reset values without a clock edge. After release the block accepts a new block normally.
5. Hold i_blk_valid high continuously with two different blocks -> second block accepted exactly one cycle after the first block's t = 63 beat, and never during STREAM.
6. With SHA256_SCHED_KT_EN defined, run scenario 1 -> o_kt = 0x428A2F98 at t = 0 and 0xC67178F2 at t = 63. Without the macro the design elaborates with no o_kt port.
